// File: rtl/saturn_jump_unit_if.sv
// Decoder/nibble-bus side of the Saturn jump unit: decoded jump fields in,
// PC-load request out.
interface saturn_jump_unit_if #(
    parameter int ADDR_W = 20
);
    logic [3:0]        i_phases;
    logic              i_bus_busy;
    logic [3:0]        i_nibble;
    logic [3:0]        i_instr_type;
    logic              i_instr_execute;
    logic [2:0]        i_jump_length;
    logic              i_jump_relative;
    logic [ADDR_W-1:0] i_instr_pc;
    logic              o_jump_busy;
    logic              o_pc_load;
    logic [ADDR_W-1:0] o_new_pc;
    logic              o_jump_error;

    modport master (
        output i_phases, i_bus_busy, i_nibble, i_instr_type, i_instr_execute,
               i_jump_length, i_jump_relative, i_instr_pc,
        input  o_jump_busy, o_pc_load, o_new_pc, o_jump_error
    );

    modport slave (
        input  i_phases, i_bus_busy, i_nibble, i_instr_type, i_instr_execute,
               i_jump_length, i_jump_relative, i_instr_pc,
        output o_jump_busy, o_pc_load, o_new_pc, o_jump_error
    );
endinterface

// File: rtl/saturn_jump_unit.sv
// Saturn GOTO/GOVLNG jump unit: gathers LSB-first offset nibbles and issues a
// single PC-load request with the computed target address.
module saturn_jump_unit #(
    parameter logic [3:0] INSTR_TYPE_JUMP = 4'd2,
    parameter int         ADDR_W          = 20
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clk_en,
    saturn_jump_unit_if.slave  bus
);
    localparam int ACC_W = 20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_COMPUTE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ACC_W-1:0]    r_acc;
    logic [2:0]          r_cnt;
    logic [2:0]          r_len;
    logic                r_rel;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_busy;
    logic                r_pc_load;
    logic [ADDR_W-1:0]   r_new_pc;
    logic                r_error;

    logic                w_qual;
    logic                w_enter;
    logic                w_set_err;
    logic                w_capture;
    logic                w_compute;
    logic                w_unused_phases;

    // Offset occupies nibbles 0..len; shift its top bit up to bit 19 and back.
    function automatic logic [ADDR_W-1:0] sext_offset(input logic [ACC_W-1:0] acc,
                                                      input logic [2:0] len);
        logic [4:0]              sh;
        logic signed [ACC_W-1:0] t;
        sh = 5'd16 - {len, 2'b00};
        t  = $signed(acc << sh) >>> sh;
        return ADDR_W'(t);
    endfunction

    assign w_qual          = i_clk_en && !bus.i_bus_busy;
    assign w_unused_phases = ^bus.i_phases[1:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_enter      = 1'b0;
        w_set_err    = 1'b0;
        w_capture    = 1'b0;
        w_compute    = 1'b0;
        if (w_qual) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_phases[2] && bus.i_instr_execute &&
                        bus.i_instr_type == INSTR_TYPE_JUMP) begin
                        if (bus.i_jump_length > 3'd4) begin
                            w_set_err = 1'b1;
                        end else begin
                            w_enter      = 1'b1;
                            w_state_next = S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (bus.i_phases[2]) begin
                        w_capture = 1'b1;
                        if (r_cnt == r_len) w_state_next = S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (bus.i_phases[3]) begin
                        w_compute    = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_rel     <= 1'b0;
            r_pc      <= '0;
            r_busy    <= 1'b0;
            r_pc_load <= 1'b0;
            r_new_pc  <= '0;
            r_error   <= 1'b0;
        end else begin
            // The load request is a strict one-clock pulse, qualified or not.
            r_pc_load <= 1'b0;
            if (w_set_err) r_error <= 1'b1;
            if (w_enter) begin
                r_len  <= bus.i_jump_length;
                r_rel  <= bus.i_jump_relative;
                r_pc   <= bus.i_instr_pc;
                r_acc  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end
            if (w_capture) begin
                r_acc[{r_cnt, 2'b00} +: 4] <= bus.i_nibble;
                r_cnt                      <= r_cnt + 3'd1;
            end
            if (w_compute) begin
                if (r_rel) r_new_pc <= r_pc + ADDR_W'(1) + sext_offset(r_acc, r_len);
                else       r_new_pc <= ADDR_W'(r_acc);
                r_pc_load <= 1'b1;
                r_busy    <= 1'b0;
            end
        end
    end

    assign bus.o_jump_busy  = r_busy;
    assign bus.o_pc_load    = r_pc_load;
    assign bus.o_new_pc     = r_new_pc;
    assign bus.o_jump_error = r_error;
endmodule

// File: tb/tb_saturn_jump_unit.sv
// Directed bench for saturn_jump_unit: expected targets are queued when a jump
// is launched and compared when the PC-load pulse appears.
module tb_saturn_jump_unit;
    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    logic i_clk_en = 1'b1;

    saturn_jump_unit_if #(.ADDR_W(20)) bus ();

    saturn_jump_unit #(.INSTR_TYPE_JUMP(4'd2), .ADDR_W(20)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clk_en (i_clk_en),
        .bus      (bus)
    );

    always #5 i_clk = ~i_clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pulses = 0;
    int          busy_p2 = 0;
    bit          rand_en = 1'b0;
    logic        prev_load = 1'b0;
    logic [19:0] exp_q[$];
    logic [19:0] exp_pc;

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every load pulse must match the oldest queued target.
    always @(negedge i_clk) begin
        if (!i_reset && bus.o_pc_load === 1'b1) begin
            n_pulses++;
            n_tests++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_pc_load: observed %h expected none", bus.o_new_pc);
            end
            if (exp_q.size() > 0) begin
                exp_pc = exp_q.pop_front();
                n_tests++;
                assert (bus.o_new_pc === exp_pc) else begin
                    n_fail++;
                    $error("FAIL new_pc: observed %h expected %h", bus.o_new_pc, exp_pc);
                end
            end
            n_tests++;
            assert (prev_load !== 1'b1) else begin
                n_fail++;
                $error("FAIL pc_load_width: observed %0d expected %0d", 2, 1);
            end
        end
        prev_load = bus.o_pc_load;
    end

    // One qualified clock with the given phase strobe, optionally preceded by
    // a few clock-enable-low cycles carrying the same inputs.
    task automatic slot(input logic [3:0] ph, input logic [3:0] nib);
        bus.i_phases = ph;
        bus.i_nibble = nib;
        if (rand_en) begin
            for (int s = 0; s < 3; s++) begin
                if ($urandom_range(0, 1) == 0) begin
                    i_clk_en = 1'b0;
                    @(posedge i_clk); #1;
                end
            end
        end
        i_clk_en = 1'b1;
        bus.i_bus_busy = 1'b0;
        if (ph[2] && bus.o_jump_busy === 1'b1) busy_p2++;
        @(posedge i_clk); #1;
    endtask

    task automatic bus_stall(input int n);
        bus.i_bus_busy = 1'b1;
        bus.i_phases   = 4'b0100;
        bus.i_nibble   = 4'hE;
        for (int s = 0; s < n; s++) begin
            @(posedge i_clk); #1;
        end
        bus.i_bus_busy = 1'b0;
    endtask

    task automatic rest_slots();
        slot(4'b1000, 4'h0);
        slot(4'b0001, 4'h0);
        slot(4'b0010, 4'h0);
    endtask

    // Full jump: entry slot, len+1 offset nibbles, then the phase-3 compute slot.
    task automatic jump(input string tag, input logic [19:0] pc, input logic [2:0] len,
                        input logic rel, input logic [19:0] nibs, input logic [19:0] exp,
                        input int stall_after, input bit b2b);
        bus.i_instr_type    = 4'd2;
        bus.i_instr_execute = 1'b1;
        bus.i_jump_length   = len;
        bus.i_jump_relative = rel;
        bus.i_instr_pc      = pc;
        exp_q.push_back(exp);
        busy_p2 = 0;
        slot(4'b0100, rel ? 4'h6 : 4'hD);
        check({tag, "_busy_entry"}, 20'(bus.o_jump_busy), 20'd1);
        rest_slots();
        for (int k = 0; k <= int'(len); k++) begin
            slot(4'b0100, nibs[4*k +: 4]);
            if (k == stall_after) bus_stall(6);
            if (k != int'(len)) begin
                rest_slots();
            end
        end
        slot(4'b1000, 4'h0);
        check({tag, "_pc_load_latency"}, 20'(bus.o_pc_load), 20'd1);
        check({tag, "_busy_drop"}, 20'(bus.o_jump_busy), 20'd0);
        check({tag, "_busy_p2_slots"}, 20'(busy_p2), 20'(int'(len) + 1));
        bus.i_instr_execute = b2b;
        if (!b2b) begin
            slot(4'b0001, 4'h0);
            check({tag, "_pc_load_clear"}, 20'(bus.o_pc_load), 20'd0);
            slot(4'b0010, 4'h0);
        end
    endtask

    int pulses_before;

    initial begin
        bus.i_phases = 4'b0001; bus.i_bus_busy = 1'b0; bus.i_nibble = 4'h0;
        bus.i_instr_type = 4'd0; bus.i_instr_execute = 1'b0; bus.i_jump_length = 3'd0;
        bus.i_jump_relative = 1'b0; bus.i_instr_pc = 20'h0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        check("rst_busy", 20'(bus.o_jump_busy), 20'd0);
        check("rst_pc_load", 20'(bus.o_pc_load), 20'd0);
        check("rst_new_pc", bus.o_new_pc, 20'h0);
        check("rst_error", 20'(bus.o_jump_error), 20'd0);

        jump("goto_fwd", 20'h00100, 3'd2, 1'b1, 20'h00035, 20'h00136, -1, 1'b0);
        jump("goto_back", 20'h00002, 3'd2, 1'b1, 20'h00FFF, 20'h00002, -1, 1'b0);
        jump("goto_wrap", 20'h00000, 3'd2, 1'b1, 20'h00800, 20'hFF801, -1, 1'b0);
        // GOVLNG immediately followed by a GOTO entered while pc_load is high.
        jump("govlng_b2b", 20'h00400, 3'd4, 1'b0, 20'h12345, 20'h12345, -1, 1'b1);
        jump("goto_after_b2b", 20'h00100, 3'd2, 1'b1, 20'h00035, 20'h00136, -1, 1'b0);

        rand_en = 1'b1;
        jump("govlng_stall", 20'h00400, 3'd4, 1'b0, 20'h12345, 20'h12345, 1, 1'b0);
        rand_en = 1'b0;

        // Reset in the middle of a GOVLNG collection.
        pulses_before = n_pulses;
        bus.i_instr_type = 4'd2; bus.i_instr_execute = 1'b1;
        bus.i_jump_length = 3'd4; bus.i_jump_relative = 1'b0;
        slot(4'b0100, 4'hD); rest_slots();
        slot(4'b0100, 4'h5); rest_slots();
        slot(4'b0100, 4'h4);
        bus.i_instr_execute = 1'b0;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        check("midrst_busy", 20'(bus.o_jump_busy), 20'd0);
        check("midrst_new_pc", bus.o_new_pc, 20'h0);
        check("midrst_pc_load", 20'(bus.o_pc_load), 20'd0);
        rest_slots(); slot(4'b0100, 4'h3); rest_slots();
        check("midrst_no_pulse", 20'(n_pulses), 20'(pulses_before));
        jump("goto_after_rst", 20'h00100, 3'd2, 1'b1, 20'h00035, 20'h00136, -1, 1'b0);

        // Non-jump instruction must be ignored.
        pulses_before = n_pulses;
        bus.i_instr_type = 4'd5; bus.i_instr_execute = 1'b1; bus.i_jump_length = 3'd2;
        for (int k = 0; k < 4; k++) begin
            slot(4'b0100, 4'h7);
            check("filter_busy", 20'(bus.o_jump_busy), 20'd0);
            rest_slots();
        end
        check("filter_no_pulse", 20'(n_pulses), 20'(pulses_before));

        // Illegal length flags a sticky error and starts nothing.
        bus.i_instr_type = 4'd2; bus.i_jump_length = 3'd5;
        slot(4'b0100, 4'h6);
        bus.i_instr_execute = 1'b0;
        check("err_set", 20'(bus.o_jump_error), 20'd1);
        check("err_no_busy", 20'(bus.o_jump_busy), 20'd0);
        rest_slots();
        jump("goto_with_err", 20'h00100, 3'd2, 1'b1, 20'h00035, 20'h00136, -1, 1'b0);
        check("err_sticky", 20'(bus.o_jump_error), 20'd1);
        check("err_no_stray_pulse", 20'(n_pulses), 20'(pulses_before + 1));
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        check("err_cleared", 20'(bus.o_jump_error), 20'd0);

        check("queue_drained", 20'(exp_q.size()), 20'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/saturn_jump_unit.md
Name: saturn_jump_unit

Overview:
- Downstream consumer of the instruction decoder for `INSTR_TYPE_JUMP` instructions.
- Collects the jump-offset nibbles streamed on the nibble bus while the decoder counts them, and computes the 20-bit target address.
  - Relative form: GOTO `6xxx`.
  - Absolute form: GOVLNG `8Dxxxxx`.
- Issues a single PC-load request to the PC/fetch logic.

Parameters:
- `INSTR_TYPE_JUMP`, default 4'd2: instruction-type code that identifies a jump; must equal the decoder's `INSTR_TYPE_JUMP` define.
- `ADDR_W`, default 20: address width; the PC wraps modulo 2^ADDR_W.

Ports:
- `i_clk`  in  1  clock
- `i_reset`  in  1  synchronous, active-high reset
- `i_clk_en`  in  1  global clock enable; no state changes when low
- `i_phases`  in  4  one-hot phase strobes; nibble valid in `[2]`, PC update in `[3]`
- `i_bus_busy`  in  1  bus transfer in progress; stalls all activity
- `i_nibble`  in  4  current instruction nibble
- `i_instr_type`  in  4  decoded instruction type
- `i_instr_execute`  in  1  decoder has started execution of the instruction
- `i_jump_length`  in  3  index of last offset nibble (0-based); nibble count = length+1
- `i_jump_relative`  in  1  1 = PC-relative signed offset, 0 = absolute address
- `i_instr_pc`  in  20  address of the first opcode nibble of the instruction
- `o_jump_busy`  out  1  offset collection in progress
- `o_pc_load`  out  1  one-cycle request to load `o_new_pc` into PC
- `o_new_pc`  out  20  computed target address
- `o_jump_error`  out  1  sticky; length > 4 seen

Behaviour:
- Reset values:
  - `o_jump_busy`=0, `o_pc_load`=0, `o_new_pc`=0, `o_jump_error`=0.
  - State=IDLE, offset accumulator=0, nibble counter=0.
  - Reset mid-collection aborts to IDLE with no `o_pc_load`.
  - `i_reset` has priority over `i_clk_en`.
- Qualifier:
  - Every transition below additionally requires `i_clk_en`=1 and `i_bus_busy`=0.
  - When not qualified, all state and outputs hold, except `o_pc_load`, which still clears (pulse never stretches).
- IDLE:
  - Entry condition: `i_phases[2]` && `i_instr_execute` && `i_instr_type`==`INSTR_TYPE_JUMP`.
  - On entry: latch length, relative flag, and `i_instr_pc`; clear accumulator and counter; assert `o_jump_busy`; go to COLLECT.
  - The nibble present in the entry phase is the opcode/sub-opcode and is not captured.
  - Length > 4: set `o_jump_error`, stay IDLE.
- COLLECT:
  - On each `i_phases[2]`, write `i_nibble` into accumulator bits `[4k+3:4k]`, k = counter (LSB-first, Saturn order), then increment counter.
  - When the captured k == latched length, go to COMPUTE.
- COMPUTE (next `i_phases[3]`):
  - Absolute: `o_new_pc` = accumulator[19:0].
  - Relative: `o_new_pc` = (latched `instr_pc` + 1 + sign-extended offset) mod 2^20.
    - The offset is sign-extended from bit 4*(length+1)-1; 12-bit for GOTO.
  - Pulse `o_pc_load`=1 for exactly one `i_clk_en` cycle.
  - Drop `o_jump_busy`; go to IDLE.
- Latency: `o_pc_load` is asserted in the phase-3 slot immediately after the last offset nibble.
- Simultaneous events:
  - A new jump qualifier while busy is ignored.
  - A new jump is accepted in the same cycle `o_pc_load` is high (back-to-back jumps).
- `o_new_pc` holds its last value until the next COMPUTE.
- Arithmetic: all adds 20-bit, overflow discarded; no carry output.

Test Plan:
- GOTO forward:
  - Stimulus: `instr_pc`=0x00100, type=JUMP, length=2, rel=1, nibbles 5,3,0 (offset 0x035).
  - Required: one `o_pc_load` pulse, `o_new_pc`=0x00136, `o_jump_busy` high for exactly 3 phase-2 slots.
- GOTO backward with wrap:
  - Stimulus: `instr_pc`=0x00002, nibbles F,F,F (offset -1).
  - Required: `o_new_pc`=0x00002; with `instr_pc`=0x00000 and offset 0x800 (-2048), `o_new_pc`=0xFF801.
- GOVLNG:
  - Stimulus: length=4, rel=0, nibbles 5,4,3,2,1.
  - Required: `o_new_pc`=0x12345, single `o_pc_load`.
- Stall:
  - Stimulus: assert `i_bus_busy` for 6 cycles between nibbles 2 and 3 of GOVLNG, and drop `i_clk_en` randomly.
  - Required: same result 0x12345, no extra or lost nibbles, `o_pc_load` width 1.
- Reset:
  - Stimulus: `i_reset` after the 2nd nibble of GOVLNG.
  - Required: next cycle `o_jump_busy`=0, `o_new_pc`=0, no `o_pc_load`; a subsequent GOTO (0x00100, 5,3,0) still yields 0x00136.
- Filter/error:
  - Stimulus: type≠JUMP with `i_instr_execute`=1.
  - Required: no activity.
  - Stimulus: length=5.
  - Required: `o_jump_error`=1 and sticky until reset.
